rat_io_port_bank: RTL and testbench

Parametrised, memory-mapped I/O port bank for the RAT MCU. It replaces hand-written per-ID output registers and the input mux with a generic block that provides:
- N_OUT writable output registers, each with an optional PWM output (RGB/LED dimming).
- N_IN synchronised input channels.
- A change-detect interrupt unit with mask and write-1-to-clear status.
Sits between RAT_MCU (PORT_ID/OUT_PORT/IO_STRB/IN_PORT) and board pins.

---
 rtl/rat_io_pkg.sv | 27 ++
 rtl/io_sync_edge.sv | 38 +++
 rtl/rat_io_port_bank.sv | 125 ++++++++++++
 tb/tb_rat_io_port_bank.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rat_io_pkg.sv
// Shared definitions for the RAT MCU I/O port bank: default widths, board port IDs
// and address-map helpers used at elaboration time.
package rat_io_pkg;

  localparam int DATA_W_DEF = 8;

  typedef logic [7:0] port_id_t;

  localparam port_id_t SWITCHES_ID = 8'h20;
  localparam port_id_t BUTTONS_ID  = 8'h21;
  localparam port_id_t LEDS_ID     = 8'h40;
  localparam port_id_t RGB_R_ID    = 8'h41;
  localparam port_id_t RGB_G_ID    = 8'h42;
  localparam port_id_t RGB_B_ID    = 8'h43;
  localparam port_id_t IRQ_STAT_ID = 8'hF0;
  localparam port_id_t IRQ_MASK_ID = 8'hF1;

  function automatic port_id_t id_at(input port_id_t base, input int off);
    return port_id_t'(int'(base) + off);
  endfunction

  // Half-open ranges [a, a+na) and [b, b+nb) share at least one ID.
  function automatic bit ranges_overlap(input int a, input int na, input int b, input int nb);
    return (a < b + nb) && (b < a + na);
  endfunction

endpackage

// File: rtl/io_sync_edge.sv
// Two-flop synchroniser for one input channel, plus a previous-value register
// so the owner can detect any bit change on the synchronised value.
module io_sync_edge #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] sync_o,
  output logic         changed_o
);

  logic [W-1:0] sync1_q, sync1_d;
  logic [W-1:0] sync2_q, sync2_d;
  logic [W-1:0] prev_q,  prev_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o    = sync2_q;
  assign changed_o = |(sync2_q ^ prev_q);

endmodule

// File: rtl/rat_io_port_bank.sv
// Memory-mapped I/O port bank for the RAT MCU: writable output registers with PWM,
// synchronised input channels and a maskable change-detect interrupt.
module rat_io_port_bank
  import rat_io_pkg::*;
#(
  parameter int       DATA_W   = DATA_W_DEF,
  parameter int       N_OUT    = 4,
  parameter int       N_IN     = 2,
  parameter port_id_t OUT_BASE = LEDS_ID,
  parameter port_id_t IN_BASE  = SWITCHES_ID,
  parameter port_id_t IRQ_ID   = IRQ_STAT_ID,
  parameter bit       PWM_EN   = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [7:0]              PORT_ID,
  input  logic [DATA_W-1:0]       OUT_PORT,
  input  logic                    IO_STRB,
  output logic [DATA_W-1:0]       IN_PORT,
  input  logic [N_IN*DATA_W-1:0]  EXT_IN,
  output logic [N_OUT*DATA_W-1:0] OUT_REGS,
  output logic [N_OUT-1:0]        PWM_OUT,
  output logic                    INTR
);

  localparam port_id_t MASK_ID = id_at(IRQ_ID, 1);

  if (N_IN < 1 || N_IN > DATA_W) begin : g_bad_n_in
    $fatal(1, "rat_io_port_bank: N_IN must be in 1..DATA_W");
  end
  if (N_OUT < 1 || N_OUT > 16) begin : g_bad_n_out
    $fatal(1, "rat_io_port_bank: N_OUT must be in 1..16");
  end
  if (ranges_overlap(int'(OUT_BASE), N_OUT, int'(IN_BASE), N_IN) ||
      ranges_overlap(int'(OUT_BASE), N_OUT, int'(IRQ_ID), 2) ||
      ranges_overlap(int'(IN_BASE), N_IN, int'(IRQ_ID), 2)) begin : g_bad_map
    $fatal(1, "rat_io_port_bank: OUT/IN/IRQ port ranges overlap");
  end

  logic [DATA_W-1:0] regs_q [N_OUT];
  logic [DATA_W-1:0] regs_d [N_OUT];
  logic [N_IN-1:0]   mask_q, mask_d;
  logic [N_IN-1:0]   pending_q, pending_d;
  logic [DATA_W-1:0] sync2 [N_IN];
  logic [N_IN-1:0]   changed;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    io_sync_edge #(.W(DATA_W)) u_sync (
      .clk      (CLK),
      .rst_n    (RESET_N),
      .async_in (EXT_IN[i*DATA_W +: DATA_W]),
      .sync_o   (sync2[i]),
      .changed_o(changed[i])
    );
  end

  // A change on the same edge as a clear write wins, so no event is lost.
  always_comb begin
    regs_d    = regs_q;
    mask_d    = mask_q;
    pending_d = pending_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (IO_STRB && PORT_ID == id_at(OUT_BASE, k)) regs_d[k] = OUT_PORT;
    end
    if (IO_STRB && PORT_ID == MASK_ID) mask_d = OUT_PORT[N_IN-1:0];
    if (IO_STRB && PORT_ID == IRQ_ID)  pending_d = pending_q & ~OUT_PORT[N_IN-1:0];
    pending_d = pending_d | changed;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      regs_q    <= '{default: '0};
      mask_q    <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    IN_PORT = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (PORT_ID == id_at(IN_BASE, i)) IN_PORT = sync2[i];
    end
    for (int k = 0; k < N_OUT; k++) begin
      if (PORT_ID == id_at(OUT_BASE, k)) IN_PORT = regs_q[k];
    end
    if (PORT_ID == IRQ_ID)  IN_PORT[N_IN-1:0] = pending_q;
    if (PORT_ID == MASK_ID) IN_PORT[N_IN-1:0] = mask_q;
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign OUT_REGS[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign INTR = |(pending_q & mask_q);

  if (PWM_EN) begin : g_pwm
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [N_OUT-1:0]  pwm_q, pwm_d;

    always_comb begin
      cnt_d = cnt_q + 1'b1;
      pwm_d = '0;
      for (int k = 0; k < N_OUT; k++) pwm_d[k] = (cnt_q < regs_q[k]);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        cnt_q <= '0;
        pwm_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        pwm_q <= pwm_d;
      end
    end

    assign PWM_OUT = pwm_q;
  end else begin : g_no_pwm
    assign PWM_OUT = '0;
  end

endmodule

// File: tb/tb_rat_io_port_bank.sv
// Directed bench for rat_io_port_bank: a per-cycle vector table for the register,
// input, interrupt paths, then PWM duty and asynchronous reset sequences.
module tb_rat_io_port_bank;

  logic        CLK;
  logic        RESET_N;
  logic [7:0]  PORT_ID;
  logic [7:0]  OUT_PORT;
  logic        IO_STRB;
  logic [7:0]  IN_PORT;
  logic [15:0] EXT_IN;
  logic [31:0] OUT_REGS;
  logic [3:0]  PWM_OUT;
  logic        INTR;

  rat_io_port_bank dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .PORT_ID (PORT_ID),
    .OUT_PORT(OUT_PORT),
    .IO_STRB (IO_STRB),
    .IN_PORT (IN_PORT),
    .EXT_IN  (EXT_IN),
    .OUT_REGS(OUT_REGS),
    .PWM_OUT (PWM_OUT),
    .INTR    (INTR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        strb;
    logic [7:0]  id;
    logic [7:0]  wdata;
    logic [15:0] ext;
    logic [7:0]  exp_rd;
    logic        exp_intr;
    logic [31:0] exp_regs;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic drive(input logic strb, input logic [7:0] id, input logic [7:0] wd);
    @(negedge CLK);
    IO_STRB  = strb;
    PORT_ID  = id;
    OUT_PORT = wd;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi [4];
    string nm;

    // Each row: inputs held across one rising edge, outputs checked just after it.
    //            strb  id     wdata  ext        rd     intr  regs
    vecs[0]  = '{1'b1, 8'h42, 8'hA5, 16'h0000, 8'hA5, 1'b0, 32'h00A5_0000};
    vecs[1]  = '{1'b0, 8'h40, 8'h00, 16'h0000, 8'h00, 1'b0, 32'h00A5_0000};
    vecs[2]  = '{1'b1, 8'h44, 8'hFF, 16'h0000, 8'h00, 1'b0, 32'h00A5_0000};
    vecs[3]  = '{1'b0, 8'h20, 8'h00, 16'h003C, 8'h00, 1'b0, 32'h00A5_0000};
    vecs[4]  = '{1'b0, 8'h20, 8'h00, 16'h003C, 8'h3C, 1'b0, 32'h00A5_0000};
    vecs[5]  = '{1'b0, 8'hF0, 8'h00, 16'h003C, 8'h01, 1'b0, 32'h00A5_0000};
    vecs[6]  = '{1'b1, 8'hF1, 8'h01, 16'h003C, 8'h01, 1'b1, 32'h00A5_0000};
    vecs[7]  = '{1'b1, 8'hF0, 8'h01, 16'h003C, 8'h00, 1'b0, 32'h00A5_0000};
    vecs[8]  = '{1'b0, 8'hF0, 8'h00, 16'h003D, 8'h00, 1'b0, 32'h00A5_0000};
    vecs[9]  = '{1'b0, 8'hF0, 8'h00, 16'h003D, 8'h00, 1'b0, 32'h00A5_0000};
    vecs[10] = '{1'b0, 8'hF0, 8'h00, 16'h003D, 8'h01, 1'b1, 32'h00A5_0000};
    vecs[11] = '{1'b0, 8'hF0, 8'h00, 16'h553D, 8'h01, 1'b1, 32'h00A5_0000};
    vecs[12] = '{1'b0, 8'hF0, 8'h00, 16'h553D, 8'h01, 1'b1, 32'h00A5_0000};
    vecs[13] = '{1'b1, 8'hF0, 8'h02, 16'h553D, 8'h03, 1'b1, 32'h00A5_0000};
    vecs[14] = '{1'b1, 8'hF0, 8'h02, 16'h553D, 8'h01, 1'b1, 32'h00A5_0000};
    vecs[15] = '{1'b0, 8'h21, 8'h00, 16'h553D, 8'h55, 1'b1, 32'h00A5_0000};
    vecs[16] = '{1'b1, 8'hF1, 8'h00, 16'h553D, 8'h00, 1'b0, 32'h00A5_0000};
    vecs[17] = '{1'b1, 8'h40, 8'h40, 16'h553D, 8'h40, 1'b0, 32'h00A5_0040};
    vecs[18] = '{1'b1, 8'h43, 8'h7E, 16'h553D, 8'h7E, 1'b0, 32'h7EA5_0040};

    RESET_N  = 1'b0;
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h20;
    OUT_PORT = 8'h00;
    EXT_IN   = 16'h0000;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset OUT_REGS", OUT_REGS, 32'h0);
    chk("reset INTR", {31'b0, INTR}, 32'h0);
    chk("reset PWM_OUT", {28'b0, PWM_OUT}, 32'h0);
    chk("reset IN_PORT", {24'b0, IN_PORT}, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      IO_STRB  = vecs[i].strb;
      PORT_ID  = vecs[i].id;
      OUT_PORT = vecs[i].wdata;
      EXT_IN   = vecs[i].ext;
      @(posedge CLK);
      #1;
      nm = $sformatf("vec%0d IN_PORT", i);
      chk(nm, {24'b0, IN_PORT}, {24'b0, vecs[i].exp_rd});
      nm = $sformatf("vec%0d INTR", i);
      chk(nm, {31'b0, INTR}, {31'b0, vecs[i].exp_intr});
      nm = $sformatf("vec%0d OUT_REGS", i);
      chk(nm, OUT_REGS, vecs[i].exp_regs);
    end

    // PWM duty with regs = {7E, A5, 00, 40}
    drive(1'b0, 8'h00, 8'h00);
    drive(1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) hi[k] = 0;
    for (int c = 0; c < 256; c++) begin
      @(posedge CLK);
      #1;
      for (int k = 0; k < 4; k++) hi[k] += int'(PWM_OUT[k]);
    end
    chk("pwm0 duty 0x40", hi[0], 64);
    chk("pwm1 duty 0x00", hi[1], 0);
    chk("pwm2 duty 0xA5", hi[2], 165);
    chk("pwm3 duty 0x7E", hi[3], 126);

    drive(1'b1, 8'h40, 8'h00);
    drive(1'b1, 8'h41, 8'hFF);
    drive(1'b0, 8'h00, 8'h00);
    drive(1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) hi[k] = 0;
    for (int c = 0; c < 256; c++) begin
      @(posedge CLK);
      #1;
      for (int k = 0; k < 4; k++) hi[k] += int'(PWM_OUT[k]);
    end
    chk("pwm0 duty 0x00", hi[0], 0);
    chk("pwm1 duty 0xFF", hi[1], 255);

    // Asynchronous reset mid-PWM with the interrupt raised
    drive(1'b1, 8'hF1, 8'h01);
    drive(1'b0, 8'h00, 8'h00);
    chk("pre-reset INTR", {31'b0, INTR}, 32'h1);
    #2;
    RESET_N = 1'b0;
    EXT_IN  = 16'h0000;
    #1;
    chk("async reset OUT_REGS", OUT_REGS, 32'h0);
    chk("async reset PWM_OUT", {28'b0, PWM_OUT}, 32'h0);
    chk("async reset INTR", {31'b0, INTR}, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 8'h40 + 8'(k), 8'h00);
      nm = $sformatf("post-reset readback reg%0d", k);
      chk(nm, {24'b0, IN_PORT}, 32'h0);
    end
    drive(1'b0, 8'hF0, 8'h00);
    chk("post-reset pending", {24'b0, IN_PORT}, 32'h0);
    drive(1'b0, 8'hF1, 8'h00);
    chk("post-reset mask", {24'b0, IN_PORT}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
